// File: rtl/noc_alloc_pkg.sv
// noc_alloc_pkg: shared state type, stats width and round-robin pointer helper
package noc_alloc_pkg;
    typedef enum logic {ALLOC_IDLE, ALLOC_LOCKED} alloc_state_e;
    localparam int STAT_WIDTH = 32;
    function automatic int unsigned rr_next(int unsigned ptr, int unsigned n);
        return (ptr + 1 >= n) ? 0 : ptr + 1;
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after the priority pointer
module rr_arbiter #(
    parameter int NUM_INPUTS = 5,
    parameter int SEL_WIDTH  = $clog2(NUM_INPUTS)
) (
    input  logic [NUM_INPUTS-1:0] i_req,
    input  logic [SEL_WIDTH-1:0]  i_ptr,
    output logic [NUM_INPUTS-1:0] o_grant,
    output logic [SEL_WIDTH-1:0]  o_winner,
    output logic                  o_any
);
    // Walk offsets from farthest to nearest so the closest request to the pointer wins last.
    always_comb begin
        o_grant  = '0;
        o_winner = '0;
        o_any    = 1'b0;
        for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
            int p;
            p = int'(i_ptr) + k;
            if (p >= NUM_INPUTS) p = p - NUM_INPUTS;
            if (i_req[p]) begin
                o_grant    = '0;
                o_grant[p] = 1'b1;
                o_winner   = SEL_WIDTH'(p);
                o_any      = 1'b1;
            end
        end
    end
endmodule

// File: rtl/router_output_allocator.sv
// router_output_allocator: per-output round-robin switch allocator with wormhole locking and credits.
// Define ROUTER_ALLOC_STATS_EN to add flit and credit-stall counters.
module router_output_allocator
    import noc_alloc_pkg::*;
#(
    parameter int NUM_INPUTS        = 5,
    parameter int FLIT_BUFFER_DEPTH = 4,
    parameter int SEL_WIDTH         = $clog2(NUM_INPUTS),
    parameter int CNT_WIDTH         = $clog2(FLIT_BUFFER_DEPTH + 1)
) (
    input  logic                  i_clk_noc,
    input  logic                  i_rst_noc_sync,
    input  logic [NUM_INPUTS-1:0] i_req,
    input  logic [NUM_INPUTS-1:0] i_req_is_tail,
    input  logic [NUM_INPUTS-1:0] i_turn_disable,
    input  logic                  i_credit_in,
    output logic [NUM_INPUTS-1:0] o_grant,
    output logic                  o_send_out,
    output logic [SEL_WIDTH-1:0]  o_sel_out,
    output logic                  o_locked,
    output logic [CNT_WIDTH-1:0]  o_credits_avail,
    output logic                  o_credit_err
`ifdef ROUTER_ALLOC_STATS_EN
    ,
    output logic [STAT_WIDTH-1:0] o_stat_flits,
    output logic [STAT_WIDTH-1:0] o_stat_stalls
`endif
);
    localparam logic [CNT_WIDTH-1:0] DEPTH_C = CNT_WIDTH'(FLIT_BUFFER_DEPTH);

    alloc_state_e          r_state;
    logic [SEL_WIDTH-1:0]  r_rr_ptr;
    logic [SEL_WIDTH-1:0]  r_owner;
    logic [CNT_WIDTH-1:0]  r_count;
    logic                  r_credit_err;
    logic                  w_cred_ok;
    logic                  w_is_locked;
    logic [NUM_INPUTS-1:0] w_elig;
    logic [NUM_INPUTS-1:0] w_owner_oh;
    logic [NUM_INPUTS-1:0] w_arb_grant;
    logic [SEL_WIDTH-1:0]  w_arb_winner;
    logic                  w_arb_any;
    logic [NUM_INPUTS-1:0] w_grant;
    logic [SEL_WIDTH-1:0]  w_sel;
    logic                  w_send;
    logic                  w_tail;

    assign w_cred_ok   = r_count != '0;
    assign w_is_locked = r_state == ALLOC_LOCKED;
    assign w_elig      = i_req & ~i_turn_disable;
    assign w_owner_oh  = {{(NUM_INPUTS-1){1'b0}}, 1'b1} << r_owner;

    rr_arbiter #(.NUM_INPUTS(NUM_INPUTS), .SEL_WIDTH(SEL_WIDTH)) u_arb (
        .i_req    (w_elig),
        .i_ptr    (r_rr_ptr),
        .o_grant  (w_arb_grant),
        .o_winner (w_arb_winner),
        .o_any    (w_arb_any)
    );

    // A locked packet only ever competes with itself; turn masks apply to new packets only.
    always_comb begin
        w_grant = w_is_locked ? (w_owner_oh & i_req & {NUM_INPUTS{w_cred_ok}})
                              : (w_cred_ok ? w_arb_grant : '0);
        w_sel   = w_is_locked ? r_owner : ((w_arb_any && w_cred_ok) ? w_arb_winner : '0);
    end

    assign w_send          = |w_grant;
    assign w_tail          = |(w_grant & i_req_is_tail);
    assign o_grant         = w_grant;
    assign o_send_out      = w_send;
    assign o_sel_out       = w_sel;
    assign o_locked        = w_is_locked;
    assign o_credits_avail = r_count;
    assign o_credit_err    = r_credit_err;

    always_ff @(posedge i_clk_noc) begin
        if (i_rst_noc_sync) begin
            r_state      <= ALLOC_IDLE;
            r_rr_ptr     <= '0;
            r_owner      <= '0;
            r_count      <= DEPTH_C;
            r_credit_err <= 1'b0;
        end else begin
            if (w_send && w_tail) begin
                r_state  <= ALLOC_IDLE;
                r_rr_ptr <= SEL_WIDTH'(rr_next(32'(w_sel), NUM_INPUTS));
            end else if (w_send && !w_is_locked) begin
                r_state <= ALLOC_LOCKED;
                r_owner <= w_sel;
            end
            if (w_send && !i_credit_in) begin
                r_count <= r_count - CNT_WIDTH'(1);
            end else if (!w_send && i_credit_in) begin
                if (r_count == DEPTH_C) r_credit_err <= 1'b1;
                else r_count <= r_count + CNT_WIDTH'(1);
            end
        end
    end

`ifdef ROUTER_ALLOC_STATS_EN
    logic [STAT_WIDTH-1:0] r_stat_flits;
    logic [STAT_WIDTH-1:0] r_stat_stalls;
    logic                  w_stall;
    assign w_stall       = !w_cred_ok && (w_is_locked ? i_req[r_owner] : |w_elig);
    assign o_stat_flits  = r_stat_flits;
    assign o_stat_stalls = r_stat_stalls;
    always_ff @(posedge i_clk_noc) begin
        if (i_rst_noc_sync) begin
            r_stat_flits  <= '0;
            r_stat_stalls <= '0;
        end else begin
            if (w_send) r_stat_flits <= r_stat_flits + 1'b1;
            if (w_stall) r_stat_stalls <= r_stat_stalls + 1'b1;
        end
    end
`else
`endif
endmodule

// File: tb/tb_router_output_allocator.sv
// tb_router_output_allocator: directed plan scenarios plus random traffic against a behavioural model
module tb_router_output_allocator;
    localparam int N = 5;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req, tail, td;
    logic         cin;
    logic [N-1:0] grant;
    logic         send;
    logic [2:0]   sel;
    logic         lck;
    logic [2:0]   cav;
    logic         cerr;
`ifdef ROUTER_ALLOC_STATS_EN
    logic [31:0]  sf, ss;
`endif

    always #5 clk = ~clk;

    router_output_allocator #(.NUM_INPUTS(N), .FLIT_BUFFER_DEPTH(D)) dut (
        .i_clk_noc       (clk),
        .i_rst_noc_sync  (rst),
        .i_req           (req),
        .i_req_is_tail   (tail),
        .i_turn_disable  (td),
        .i_credit_in     (cin),
        .o_grant         (grant),
        .o_send_out      (send),
        .o_sel_out       (sel),
        .o_locked        (lck),
        .o_credits_avail (cav),
        .o_credit_err    (cerr)
`ifdef ROUTER_ALLOC_STATS_EN
        ,
        .o_stat_flits    (sf),
        .o_stat_stalls   (ss)
`endif
    );

    int total = 0;
    int bad   = 0;

    // Model: packet ownership, rotating priority, credit count, sticky error, stats
    bit m_lock;
    int m_owner, m_ptr, m_cred, m_sf, m_ss;
    bit m_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_lock = 0; m_owner = 0; m_ptr = 0; m_cred = D; m_err = 0; m_sf = 0; m_ss = 0;
    endtask

    function automatic int m_winner();
        if (m_cred == 0) return -1;
        if (m_lock) return req[m_owner] ? m_owner : -1;
        for (int i = 0; i < N; i++) begin
            int j;
            j = (m_ptr + i) % N;
            if (req[j] && !td[j]) return j;
        end
        return -1;
    endfunction

    task automatic drive(input logic [N-1:0] r, input logic [N-1:0] t, input logic [N-1:0] d, input logic c);
        req = r; tail = t; td = d; cin = c;
    endtask

    // Called at a negedge: checks outputs, then advances DUT and model across one posedge.
    task automatic cycle();
        int w;
        logic [N-1:0] eg;
        bit stall;
        #1;
        w = m_winner();
        eg = '0;
        if (w >= 0) eg[w] = 1'b1;
        chk("grant", grant, eg);
        chk("send_out", send, w >= 0);
        chk("sel_out", sel, w >= 0 ? w : (m_lock ? m_owner : 0));
        chk("locked", lck, m_lock);
        chk("credits_avail", cav, m_cred);
        chk("credit_err", cerr, m_err);
`ifdef ROUTER_ALLOC_STATS_EN
        chk("stat_flits", sf, m_sf);
        chk("stat_stalls", ss, m_ss);
`endif
        stall = (m_cred == 0) && (m_lock ? req[m_owner] : |(req & ~td));
        @(posedge clk);
        if (rst) m_reset();
        else begin
            if (w >= 0) m_sf++;
            if (stall) m_ss++;
            if (w >= 0) begin
                if (tail[w]) begin m_lock = 0; m_ptr = (w + 1) % N; end
                else begin m_lock = 1; m_owner = w; end
            end
            m_cred = m_cred - (w >= 0 ? 1 : 0) + (cin ? 1 : 0);
            if (m_cred > D) begin m_cred = D; m_err = 1; end
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        drive('0, '0, '0, 1'b0);
        m_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        cycle();
        #1;
        chk("reset_grant", grant, 0);
        chk("reset_credits", cav, D);
        rst = 1'b0;

        // Round-robin over single-flit packets with a credit returned every cycle
        drive(5'b11111, 5'b11111, '0, 1'b1);
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("rr_order", sel, k % N);
            cycle();
        end
        chk("rr_credits", cav, D);

        // Input 2 owns the port for a three-flit packet while 1 and 3 wait
        drive(5'b00010, 5'b00010, '0, 1'b1);
        cycle();
        drive(5'b01110, 5'b01010, '0, 1'b1);
        #1; chk("pkt_head", grant, 5'b00100);
        cycle();
        #1; chk("pkt_body_locked", lck, 1);
        cycle();
        drive(5'b01110, 5'b01110, '0, 1'b1);
        #1; chk("pkt_tail", grant, 5'b00100); chk("pkt_tail_sel", sel, 2);
        cycle();
        #1; chk("pkt_next", grant, 5'b01000);
        cycle();

        // Credit exhaustion with input 0 streaming
        drive(5'b00001, 5'b00001, '0, 1'b0);
        repeat (6) cycle();
        #1; chk("empty_credits", cav, 0); chk("empty_grant", grant, 0);
        drive(5'b00001, 5'b00001, '0, 1'b1);
        cycle();
        drive(5'b00001, 5'b00001, '0, 1'b0);
        #1; chk("one_credit_grant", grant, 5'b00001);
        cycle();
        #1; chk("one_credit_only", grant, 0);
        cycle();

        // Refill, then turn mask: blocks a new packet, ignored mid-packet
        drive('0, '0, '0, 1'b1);
        repeat (4) cycle();
        drive(5'b00010, 5'b00000, 5'b00010, 1'b0);
        #1; chk("turn_block", grant, 0);
        cycle();
        drive(5'b00010, 5'b00000, 5'b00000, 1'b0);
        cycle();
        drive(5'b00010, 5'b00000, 5'b00010, 1'b0);
        #1; chk("turn_mid_pkt", grant, 5'b00010);
        cycle();
        drive(5'b00010, 5'b00010, 5'b00010, 1'b0);
        cycle();
        #1; chk("turn_pkt_done", lck, 0);

        // Overflowing credit return sets the sticky error
        drive('0, '0, '0, 1'b1);
        repeat (4) cycle();
        drive('0, '0, '0, 1'b0);
        repeat (3) cycle();
        #1; chk("overflow_err", cerr, 1); chk("overflow_credits", cav, D);

        // Reset mid-packet with one credit left
        drive(5'b00100, 5'b00000, '0, 1'b0);
        repeat (3) cycle();
        #1; chk("pre_reset_locked", lck, 1); chk("pre_reset_credits", cav, 1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        #1; chk("post_reset_locked", lck, 0); chk("post_reset_credits", cav, D); chk("post_reset_err", cerr, 0);
`ifdef ROUTER_ALLOC_STATS_EN
        chk("post_reset_flits", sf, 0); chk("post_reset_stalls", ss, 0);
`endif
        drive(5'b11111, 5'b11111, '0, 1'b0);
        #1; chk("post_reset_ptr", grant, 5'b00001);
        cycle();

        // Random traffic
        for (int k = 0; k < 3000; k++) begin
            rst = ($urandom_range(0, 249) == 0);
            drive(N'($urandom), N'($urandom), N'($urandom & $urandom), $urandom_range(0, 1) == 1);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
